hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_ctrl_load_use_detect.sv | 18 +
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared pipeline-hazard types and constants, also used by the forwarding logic.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } hazStateT;

    localparam logic [4:0] XZR_ADDR = 5'd31;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: the EX load targets a register the ID instruction reads.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] AaID,
    input  logic [4:0] AbID,
    input  logic       useAbID,
    input  logic [4:0] AwEx,
    input  logic       MemReadEX,
    input  logic       RegWriteEX,
    output logic       loadUse
);

    // The zero register is never a real dependency.
    assign loadUse = MemReadEX && RegWriteEX && (AwEx != XZR_ADDR) &&
                     ((AwEx == AaID) || (useAbID && (AwEx == AbID)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory-busy hold.
// Define HAZARD_PERF_CNT_EN to add the stallCnt/flushCnt performance counters.
//
// state | meaning
// RUN   | normal flow; stalls for load-use, flushes IF/ID on a taken branch
// FLUSH | extra IF/ID flush cycles after a taken branch, counted by flushCtr
// HOLD  | memory busy; whole pipeline frozen, prior state/counter saved
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  AaID,
    input  logic [4:0]  AbID,
    input  logic        useAbID,
    input  logic [4:0]  AwEx,
    input  logic        MemReadEX,
    input  logic        RegWriteEX,
    input  logic        brTakenEX,
    input  logic        memBusy,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExBubble,
    output logic        exMemWrite,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt,
`endif
    output logic [1:0]  state
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    hazStateT   curState, savedState, nextState, effState;
    logic [2:0] flushCtr, savedCtr, nextCtr, effCtr;
    logic       loadUse, eventsOk;

    load_use_detect uLoadUse (
        .AaID       (AaID),
        .AbID       (AbID),
        .useAbID    (useAbID),
        .AwEx       (AwEx),
        .MemReadEX  (MemReadEX),
        .RegWriteEX (RegWriteEX),
        .loadUse    (loadUse)
    );

    // In the cycle memBusy drops, HOLD already behaves as the restored state.
    assign effState = (curState == HOLD) ? savedState : curState;
    assign effCtr   = (curState == HOLD) ? savedCtr : flushCtr;
    assign eventsOk = (curState != HOLD);
    assign state    = curState;

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        exMemWrite = 1'b1;
        nextState  = RUN;
        nextCtr    = '0;
        if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            exMemWrite = 1'b0;
            nextState  = HOLD;
        end else begin
            case (effState)
                RUN: begin
                    if (eventsOk && brTakenEX) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            nextState = FLUSH;
                            nextCtr   = FLUSH_LOAD;
                        end
                    end else if (eventsOk && loadUse) begin
                        pcWrite    = 1'b0;
                        ifIdWrite  = 1'b0;
                        idExBubble = 1'b1;
                    end
                end
                FLUSH: begin
                    ifIdFlush = 1'b1;
                    if (effCtr <= 3'd1) begin
                        nextState = RUN;
                        nextCtr   = '0;
                    end else begin
                        nextState = FLUSH;
                        nextCtr   = effCtr - 3'd1;
                    end
                end
                default: begin
                    nextState = RUN;
                    nextCtr   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState   <= RUN;
            flushCtr   <= '0;
            savedState <= RUN;
            savedCtr   <= '0;
        end else if (memBusy) begin
            if (curState != HOLD) begin
                savedState <= (curState == FLUSH) ? FLUSH : RUN;
                savedCtr   <= (curState == FLUSH) ? flushCtr : 3'd0;
            end
            curState <= HOLD;
        end else begin
            curState <= nextState;
            flushCtr <= nextCtr;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stallTaken, branchTaken;

    assign branchTaken = !memBusy && eventsOk && (effState == RUN) && brTakenEX;
    assign stallTaken  = !memBusy && eventsOk && (effState == RUN) && !brTakenEX && loadUse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallTaken && (stallCnt != 16'hFFFF))
                stallCnt <= stallCnt + 16'd1;
            if (branchTaken && (flushCnt != 16'hFFFF))
                flushCnt <= flushCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with FLUSH_CYCLES=3; table vectors plus reset corner sequences.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int FC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] AaID, AbID, AwEx;
    logic       useAbID, MemReadEX, RegWriteEX, brTakenEX, memBusy;
    logic       pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCnt, flushCnt;
`endif

    hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk        (clk),
        .reset      (reset),
        .AaID       (AaID),
        .AbID       (AbID),
        .useAbID    (useAbID),
        .AwEx       (AwEx),
        .MemReadEX  (MemReadEX),
        .RegWriteEX (RegWriteEX),
        .brTakenEX  (brTakenEX),
        .memBusy    (memBusy),
        .pcWrite    (pcWrite),
        .ifIdWrite  (ifIdWrite),
        .ifIdFlush  (ifIdFlush),
        .idExBubble (idExBubble),
        .exMemWrite (exMemWrite),
`ifdef HAZARD_PERF_CNT_EN
        .stallCnt   (stallCnt),
        .flushCnt   (flushCnt),
`endif
        .state      (state)
    );

    // Output order: pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite
    localparam logic [4:0] O_RUN   = 5'b11001;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_BR    = 5'b11111;
    localparam logic [4:0] O_FL    = 5'b11101;
    localparam logic [4:0] O_HOLD  = 5'b00000;

    typedef struct {
        logic       busy, br, mr, rw, useAb;
        logic [4:0] aw, aa, ab;
        logic [6:0] exp;
    } vecT;

    vecT        vecs[$];
    logic [6:0] expQ[$];
    int         nVec = 0;
    int         nBad = 0;

    function automatic vecT mk(input logic busy, input logic br, input logic mr, input logic rw,
                               input logic useAb, input logic [4:0] aw, input logic [4:0] aa,
                               input logic [4:0] ab, input logic [4:0] o, input logic [1:0] st);
        vecT v;
        v.busy = busy; v.br = br; v.mr = mr; v.rw = rw; v.useAb = useAb;
        v.aw = aw; v.aa = aa; v.ab = ab; v.exp = {o, st};
        return v;
    endfunction

    function automatic vecT idle(input logic [4:0] o, input logic [1:0] st);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd2, 5'd3, o, st);
    endfunction

    task automatic drive(input vecT v);
        memBusy = v.busy; brTakenEX = v.br; MemReadEX = v.mr; RegWriteEX = v.rw;
        useAbID = v.useAb; AwEx = v.aw; AaID = v.aa; AbID = v.ab;
        expQ.push_back(v.exp);
    endtask

    task automatic sampleCheck(input string tag);
        logic [6:0] got, exp;
        got = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, state};
        nVec++;
        if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL %s: no expected entry queued, got %b", tag, got);
            return;
        end
        exp = expQ.pop_front();
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: pc/ifid/flush/bubble/exmem/state got %b required %b", tag, got, exp);
        end
    endtask

    task automatic step(input vecT v, input string tag);
        @(negedge clk);
        drive(v);
        #2;
        sampleCheck(tag);
    endtask

    task automatic cmpCnt(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        memBusy = 1'b0; brTakenEX = 1'b0; MemReadEX = 1'b0; RegWriteEX = 1'b0;
        useAbID = 1'b0; AwEx = 5'd5; AaID = 5'd2; AbID = 5'd3;

        // Outputs are decoded combinationally even while reset is held.
        step(idle(O_RUN, 2'd0), "reset_idle");
        step(mk(0, 0, 1, 1, 0, 5'd5, 5'd5, 5'd3, O_STALL, 2'd0), "reset_loaduse");
        @(negedge clk) reset = 1'b1;

        vecs.push_back(idle(O_RUN, 2'd0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 5'd5,  5'd5,  5'd3,  O_STALL, 2'd0));
        vecs.push_back(idle(O_RUN, 2'd0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 5'd31, 5'd31, 5'd3,  O_RUN,   2'd0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 5'd5,  5'd2,  5'd5,  O_RUN,   2'd0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 5'd5,  5'd2,  5'd5,  O_STALL, 2'd0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 5'd5,  5'd5,  5'd3,  O_RUN,   2'd0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 5'd5,  5'd5,  5'd3,  O_RUN,   2'd0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 5'd31, 5'd2,  5'd31, O_RUN,   2'd0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5'd5,  5'd2,  5'd3,  O_BR,    2'd0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 5'd5,  5'd5,  5'd3,  O_FL,    2'd1));
        vecs.push_back(idle(O_FL, 2'd1));
        vecs.push_back(idle(O_RUN, 2'd0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 5'd5,  5'd5,  5'd3,  O_BR,    2'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 5'd5,  5'd2,  5'd3,  O_HOLD,  2'd1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 5'd5, 5'd2, 5'd3, O_HOLD, 2'd2));
        vecs.push_back(mk(0, 0, 1, 1, 0, 5'd5,  5'd5,  5'd3,  O_FL,    2'd2));
        vecs.push_back(idle(O_FL, 2'd1));
        vecs.push_back(idle(O_RUN, 2'd0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 5'd5,  5'd2,  5'd3,  O_HOLD,  2'd0));
        vecs.push_back(idle(O_RUN, 2'd2));
        vecs.push_back(idle(O_RUN, 2'd0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 5'd5,  5'd5,  5'd3,  O_HOLD,  2'd0));
        vecs.push_back(idle(O_RUN, 2'd2));
        vecs.push_back(mk(0, 0, 1, 1, 1, 5'd9,  5'd2,  5'd9,  O_STALL, 2'd0));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a flush sequence.
        step(mk(0, 1, 0, 0, 0, 5'd5, 5'd2, 5'd3, O_BR, 2'd0), "mf_branch");
        step(idle(O_FL, 2'd1), "mf_flush1");
        #1 reset = 1'b0;
        expQ.push_back({O_RUN, 2'd0});
        #1 sampleCheck("mf_reset_now");
        @(negedge clk) reset = 1'b1;
        step(idle(O_RUN, 2'd0), "mf_after1");
        step(idle(O_RUN, 2'd0), "mf_after2");

        // Reset in the middle of a hold that saved a flush.
        step(mk(0, 1, 0, 0, 0, 5'd5, 5'd2, 5'd3, O_BR, 2'd0), "mh_branch");
        step(mk(1, 0, 0, 0, 0, 5'd5, 5'd2, 5'd3, O_HOLD, 2'd1), "mh_busy1");
        step(mk(1, 0, 0, 0, 0, 5'd5, 5'd2, 5'd3, O_HOLD, 2'd2), "mh_busy2");
        #1 reset = 1'b0;
        expQ.push_back({O_HOLD, 2'd0});
        #1 sampleCheck("mh_reset_busy");
        step(idle(O_RUN, 2'd0), "mh_reset_idle");
        @(negedge clk) reset = 1'b1;
        step(idle(O_RUN, 2'd0), "mh_after1");
        step(idle(O_RUN, 2'd0), "mh_after2");

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk) reset = 1'b0;
        #2;
        cmpCnt("perf_reset_stall", stallCnt, 16'd0);
        cmpCnt("perf_reset_flush", flushCnt, 16'd0);
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(mk(0, 0, 1, 1, 0, 5'd7, 5'd7, 5'd3, O_STALL, 2'd0), $sformatf("perf_stall%0d", k));
            step(idle(O_RUN, 2'd0), $sformatf("perf_gap%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            step(mk(0, 1, 0, 0, 0, 5'd5, 5'd2, 5'd3, O_BR, 2'd0), $sformatf("perf_br%0d", k));
            step(idle(O_FL, 2'd1), $sformatf("perf_fl%0da", k));
            step(idle(O_FL, 2'd1), $sformatf("perf_fl%0db", k));
        end
        @(negedge clk);
        cmpCnt("perf_stall3", stallCnt, 16'd3);
        cmpCnt("perf_flush2", flushCnt, 16'd2);
        MemReadEX = 1'b1; RegWriteEX = 1'b1; AwEx = 5'd7; AaID = 5'd7;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        cmpCnt("perf_sat", stallCnt, 16'hFFFF);
        @(negedge clk);
        cmpCnt("perf_sat_hold", stallCnt, 16'hFFFF);
        MemReadEX = 1'b0; RegWriteEX = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
